// File: rtl/tap_fifo_arbiter.sv
// Packet-granular 2:1 arbiter draining the CQ/CC tap FIFOs into arb2encap with source tagging.
// Optional packet statistics counters are enabled by defining TXARB_STATS_EN.
//
// state  | meaning
// IDLE   | between packets, no reads; picks the next source
// GRANT0 | forwarding one packet from fifo0 (CQ)
// GRANT1 | forwarding one packet from fifo1 (CC)
module tap_fifo_arbiter #(
    parameter int IN_W       = 74,
    parameter int OUT_W      = 76,
    parameter int LAST_BIT   = 66,
    parameter int PRIO_FIXED = 0,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk156,
    input  logic             sys_rst_n,
    output logic             fifo0_rd_en,
    input  logic [IN_W-1:0]  fifo0_dout,
    input  logic             fifo0_empty,
    output logic             fifo1_rd_en,
    input  logic [IN_W-1:0]  fifo1_dout,
    input  logic             fifo1_empty,
    output logic             wr_en,
    output logic [OUT_W-1:0] din,
    input  logic             full,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t             state, state_nxt;
    logic               last_grant, last_grant_nxt;
    logic               rd_vld;
    logic [IN_W-1:0]    sel_dout;
    logic [1:0]         sel_src;
    logic               sel_last;
    logic               push;
    logic               credit;
    logic [3:0]         occ;
    logic [OUT_W-1:0]   buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [2:0]         buf_cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Returning read data always belongs to the granted source: the grant
    // is held until the last word of the packet has come back.
    always_comb begin
        sel_dout = fifo0_dout;
        sel_src  = 2'b01;
        if (state == GRANT1) begin
            sel_dout = fifo1_dout;
            sel_src  = 2'b10;
        end
    end

    assign sel_last = sel_dout[LAST_BIT];
    assign push     = rd_vld;
    assign wr_en    = (buf_cnt != 3'd0) && !full;
    assign din      = buf_mem[rd_ptr];

    // Slots committed after this edge: buffered + arriving - leaving.
    assign occ    = {1'b0, buf_cnt} + {3'b000, rd_vld} - {3'b000, wr_en};
    assign credit = occ < 4'(BUF_DEPTH);

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rd_vld     <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            rd_vld     <= fifo0_rd_en | fifo1_rd_en;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        fifo0_rd_en    = 1'b0;
        fifo1_rd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo0_empty && !fifo1_empty) begin
                    if (PRIO_FIXED != 0 || last_grant)
                        state_nxt = GRANT0;
                    else
                        state_nxt = GRANT1;
                end else if (!fifo0_empty) begin
                    state_nxt = GRANT0;
                end else if (!fifo1_empty) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (rd_vld && fifo0_dout[LAST_BIT]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = 1'b0;
                end else begin
                    fifo0_rd_en = !fifo0_empty && credit;
                end
            end
            GRANT1: begin
                if (rd_vld && fifo1_dout[LAST_BIT]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = 1'b1;
                end else begin
                    fifo1_rd_en = !fifo1_empty && credit;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_cnt <= 3'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= {sel_src, sel_dout};
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (wr_en)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !wr_en)
                buf_cnt <= buf_cnt + 3'd1;
            else if (!push && wr_en)
                buf_cnt <= buf_cnt - 3'd1;
        end
    end

`ifdef TXARB_STATS_EN
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (push && sel_last) begin
            if (sel_src[0])
                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            else
                pkt_cnt1 <= pkt_cnt1 + 1'b1;
        end
    end
`else
    assign pkt_cnt0 = '0;
    assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_tap_fifo_arbiter.sv
// Bench for tap_fifo_arbiter: round-robin instance (a) and fixed-priority instance (b)
// fed from queue-based FIFO models, outputs checked against a scoreboard.
module tb_tap_fifo_arbiter;

    localparam int DA = 2;
    localparam int DB = 3;
`ifdef TXARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk156 = 1'b0;
    always #5 clk156 = ~clk156;

    logic        sys_rst_n;
    logic        a_rd0, a_rd1, a_wr, a_full, a_e0, a_e1;
    logic [73:0] a_dout0, a_dout1;
    logic [75:0] a_din;
    logic [31:0] a_cnt0, a_cnt1;
    logic        b_rd0, b_rd1, b_wr, b_full, b_e0, b_e1;
    logic [73:0] b_dout0, b_dout1;
    logic [75:0] b_din;
    logic [31:0] b_cnt0, b_cnt1;

    tap_fifo_arbiter #(.PRIO_FIXED(0), .BUF_DEPTH(DA)) ua (
        .clk156(clk156), .sys_rst_n(sys_rst_n),
        .fifo0_rd_en(a_rd0), .fifo0_dout(a_dout0), .fifo0_empty(a_e0),
        .fifo1_rd_en(a_rd1), .fifo1_dout(a_dout1), .fifo1_empty(a_e1),
        .wr_en(a_wr), .din(a_din), .full(a_full),
        .pkt_cnt0(a_cnt0), .pkt_cnt1(a_cnt1)
    );

    tap_fifo_arbiter #(.PRIO_FIXED(1), .BUF_DEPTH(DB)) ub (
        .clk156(clk156), .sys_rst_n(sys_rst_n),
        .fifo0_rd_en(b_rd0), .fifo0_dout(b_dout0), .fifo0_empty(b_e0),
        .fifo1_rd_en(b_rd1), .fifo1_dout(b_dout1), .fifo1_empty(b_e1),
        .wr_en(b_wr), .din(b_din), .full(b_full),
        .pkt_cnt0(b_cnt0), .pkt_cnt1(b_cnt1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [73:0] qa0[$], qa1[$], qb0[$], qb1[$];
    logic [75:0] expa[$], expb[$];
    logic sa_rd0, sa_rd1, sb_rd0, sb_rd1;
    logic a_full_q, b_full_q;
    int a_rd_tot, a_wr_tot, b_rd_tot, b_wr_tot;
    int a_rd0_n, a_rd0_first, a_rd0_last;
    int e_a0, e_a1, e_b0, e_b1;
    bit bp_chk, bub_chk, a_prev_last;

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [73:0] mkw(input int s, input int id, input int k, input int n);
        logic [63:0] d;
        d = {8'(s), 8'(id), 16'(k), 32'h5A3C_0F00 ^ 32'(id * 17 + k)};
        return {6'(id + k), id[0], (k == n - 1), 2'(k), d};
    endfunction

    task automatic load(input int d, input int s, input int id, input int n, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            if (d == 0 && s == 0) qa0.push_back(mkw(s, id, k, n));
            else if (d == 0)      qa1.push_back(mkw(s, id, k, n));
            else if (s == 0)      qb0.push_back(mkw(s, id, k, n));
            else                  qb1.push_back(mkw(s, id, k, n));
        end
    endtask

    task automatic expect_pkt(input int d, input int s, input int id, input int n);
        for (int k = 0; k < n; k++) begin
            if (d == 0) expa.push_back({(s == 0) ? 2'b01 : 2'b10, mkw(s, id, k, n)});
            else        expb.push_back({(s == 0) ? 2'b01 : 2'b10, mkw(s, id, k, n)});
        end
        if (d == 0 && s == 0) e_a0++;
        else if (d == 0)      e_a1++;
        else if (s == 0)      e_b0++;
        else                  e_b1++;
    endtask

    // FIFO pops land just after the edge; inputs change on the falling edge;
    // outputs are sampled 1 ns after the falling edge.
    task automatic tick();
        @(posedge clk156);
        #1;
        cyc++;
        if (sa_rd0 && qa0.size() != 0) a_dout0 = qa0.pop_front();
        if (sa_rd1 && qa1.size() != 0) a_dout1 = qa1.pop_front();
        if (sb_rd0 && qb0.size() != 0) b_dout0 = qb0.pop_front();
        if (sb_rd1 && qb1.size() != 0) b_dout1 = qb1.pop_front();
        @(negedge clk156);
        a_e0 = (qa0.size() == 0);
        a_e1 = (qa1.size() == 0);
        b_e0 = (qb0.size() == 0);
        b_e1 = (qb1.size() == 0);
        a_full = a_full_q;
        b_full = b_full_q;
        #1;
        if (a_rd0 || a_rd1) begin
            chk("a_rd_excl", 76'(a_rd0 & a_rd1), 76'd0);
            chk("a_underflow", 76'((a_rd0 & a_e0) | (a_rd1 & a_e1)), 76'd0);
        end
        if (b_rd0 || b_rd1) begin
            chk("b_rd_excl", 76'(b_rd0 & b_rd1), 76'd0);
            chk("b_underflow", 76'((b_rd0 & b_e0) | (b_rd1 & b_e1)), 76'd0);
        end
        if (a_rd0) begin
            a_rd0_n++;
            if (a_rd0_first < 0) a_rd0_first = cyc;
            a_rd0_last = cyc;
        end
        a_rd_tot += int'(a_rd0) + int'(a_rd1);
        b_rd_tot += int'(b_rd0) + int'(b_rd1);
        if (bub_chk && a_prev_last) chk("a_bubble", 76'(a_wr), 76'd0);
        if (a_wr) begin
            a_wr_tot++;
            if (expa.size() == 0) chk("a_extra_wr", 76'(a_wr), 76'd0);
            else                  chk("a_din", a_din, expa.pop_front());
        end
        if (b_wr) begin
            b_wr_tot++;
            if (expb.size() == 0) chk("b_extra_wr", 76'(b_wr), 76'd0);
            else                  chk("b_din", b_din, expb.pop_front());
        end
        a_prev_last = a_wr && a_din[66];
        if (bp_chk) begin
            chk("a_outstanding_le", 76'((a_rd_tot - a_wr_tot) <= DA), 76'd1);
            chk("b_outstanding_le", 76'((b_rd_tot - b_wr_tot) <= DB), 76'd1);
        end
        sa_rd0 = a_rd0;
        sa_rd1 = a_rd1;
        sb_rd0 = b_rd0;
        sb_rd1 = b_rd1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((expa.size() + expb.size() + qa0.size() + qa1.size() + qb0.size() + qb1.size()) != 0
               && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", 76'(expa.size() + expb.size() + qa0.size() + qa1.size() + qb0.size() + qb1.size()), 76'd0);
        repeat (6) tick();
    endtask

    task automatic chk_stats();
        chk("a_pkt_cnt0", 76'(a_cnt0), STATS_ON ? 76'(e_a0) : 76'd0);
        chk("a_pkt_cnt1", 76'(a_cnt1), STATS_ON ? 76'(e_a1) : 76'd0);
        chk("b_pkt_cnt0", 76'(b_cnt0), STATS_ON ? 76'(e_b0) : 76'd0);
        chk("b_pkt_cnt1", 76'(b_cnt1), STATS_ON ? 76'(e_b1) : 76'd0);
    endtask

    initial begin
        int n;
        sys_rst_n = 1'b0;
        a_full = 1'b0; b_full = 1'b0; a_full_q = 1'b0; b_full_q = 1'b0;
        a_e0 = 1'b1; a_e1 = 1'b1; b_e0 = 1'b1; b_e1 = 1'b1;
        a_dout0 = '0; a_dout1 = '0; b_dout0 = '0; b_dout1 = '0;
        sa_rd0 = 1'b0; sa_rd1 = 1'b0; sb_rd0 = 1'b0; sb_rd1 = 1'b0;
        a_rd_tot = 0; a_wr_tot = 0; b_rd_tot = 0; b_wr_tot = 0;
        a_rd0_n = 0; a_rd0_first = -1; a_rd0_last = -1;
        e_a0 = 0; e_a1 = 0; e_b0 = 0; e_b1 = 0;
        bp_chk = 1'b0; bub_chk = 1'b0; a_prev_last = 1'b0;

        // Reset held with both sources non-empty, then 3x2-word packets each
        for (int p = 0; p < 3; p++)
            for (int d = 0; d < 2; d++) begin
                load(d, 0, p, 2, 0, 1);
                load(d, 1, p + 8, 2, 0, 1);
            end
        repeat (3) begin
            tick();
            chk("rst_a_ctl", 76'({a_rd0, a_rd1, a_wr}), 76'd0);
            chk("rst_a_din", a_din, 76'd0);
            chk("rst_b_ctl", 76'({b_rd0, b_rd1, b_wr}), 76'd0);
            chk("rst_b_din", b_din, 76'd0);
        end
        for (int p = 0; p < 3; p++) begin
            expect_pkt(0, 0, p, 2);
            expect_pkt(0, 1, p + 8, 2);
        end
        for (int p = 0; p < 3; p++) expect_pkt(1, 0, p, 2);
        for (int p = 0; p < 3; p++) expect_pkt(1, 1, p + 8, 2);
        sys_rst_n = 1'b1;
        bub_chk = 1'b1;
        n = 0;
        while (!(a_rd0 || a_rd1) && n < 20) begin
            tick();
            n++;
        end
        chk("a_first_grant", 76'({a_rd0, a_rd1}), 76'(2'b10));
        chk("b_first_grant", 76'({b_rd0, b_rd1}), 76'(2'b10));
        drain(200);
        bub_chk = 1'b0;
        chk_stats();

        // Single source, 4-word packet: four back-to-back reads
        a_rd0_n = 0; a_rd0_first = -1; a_rd0_last = -1;
        load(0, 0, 10, 4, 0, 3);
        expect_pkt(0, 0, 10, 4);
        drain(100);
        chk("a_rd_count", 76'(a_rd0_n), 76'd4);
        chk("a_rd_span", 76'(a_rd0_last - a_rd0_first), 76'd3);

        // Backpressure: full held 10 cycles during an 8-word packet
        load(0, 1, 20, 8, 0, 7);
        load(1, 1, 20, 8, 0, 7);
        expect_pkt(0, 1, 20, 8);
        expect_pkt(1, 1, 20, 8);
        repeat (2) tick();
        a_full_q = 1'b1;
        b_full_q = 1'b1;
        bp_chk = 1'b1;
        repeat (10) tick();
        chk("a_outstanding", 76'(a_rd_tot - a_wr_tot), 76'(DA));
        chk("b_outstanding", 76'(b_rd_tot - b_wr_tot), 76'(DB));
        chk("a_wr_during_full", 76'(a_wr), 76'd0);
        bp_chk = 1'b0;
        a_full_q = 1'b0;
        b_full_q = 1'b0;
        drain(200);

        // Source runs dry mid-packet: grant is held, other source waits
        load(0, 0, 30, 3, 0, 1);
        load(0, 1, 31, 1, 0, 0);
        expect_pkt(0, 0, 30, 3);
        expect_pkt(0, 1, 31, 1);
        repeat (8) tick();
        load(0, 0, 30, 3, 2, 2);
        drain(100);

        // Back-to-back single-word packets, and fixed priority at each boundary
        load(0, 1, 32, 1, 0, 0);
        load(0, 1, 33, 1, 0, 0);
        expect_pkt(0, 1, 32, 1);
        expect_pkt(0, 1, 33, 1);
        load(1, 0, 40, 1, 0, 0);
        load(1, 1, 41, 1, 0, 0);
        load(1, 0, 42, 1, 0, 0);
        expect_pkt(1, 0, 40, 1);
        expect_pkt(1, 0, 42, 1);
        expect_pkt(1, 1, 41, 1);
        drain(100);
        chk_stats();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
